// File: rtl/serial_frame_tx_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx_fsm_if
// Brief    : Word handshake and serial output bundle for serial_frame_tx_fsm.
// Revision : 1.0
// ============================================================================
interface serial_frame_tx_fsm_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  dout,
    input  dout_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output dout,
    output dout_valid,
    output busy,
    output done
  );
endinterface
`default_nettype wire

// File: rtl/serial_frame_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx_fsm
// Brief    : Serialises a parallel word as start bit, data LSB first, stop bit.
//            Define SERIAL_FRAME_TX_PARITY_EN to insert an even-parity bit.
// Revision : 1.0
// ============================================================================
module serial_frame_tx_fsm #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_frame_tx_fsm_if.slave tx_if
);

  localparam int c_TMR_W = $clog2(BIT_CYCLES) + 1;
  localparam int c_IDX_W = $clog2(WIDTH) + 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(BIT_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_TMR_W-1:0] r_timer;
  logic [c_IDX_W-1:0] r_idx;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic               r_parity;
`endif

  logic w_bit_last;
  logic w_ready;
  logic w_dout;
  logic w_busy;
  logic w_done;

  assign w_bit_last = (r_timer == c_TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_timer  <= '0;
      r_idx    <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tx_if.tx_valid) begin
            r_shift  <= tx_if.tx_data;
            r_timer  <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            r_parity <= ^tx_if.tx_data;
`endif
            r_state  <= S_START;
          end
        end
        S_START: begin
          if (w_bit_last) begin
            r_timer <= '0;
            r_idx   <= '0;
            r_state <= S_DATA;
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end
        S_DATA: begin
          if (w_bit_last) begin
            r_timer <= '0;
            r_shift <= r_shift >> 1;
            if (r_idx == c_IDX_LAST) begin
              r_idx   <= '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_idx <= r_idx + c_IDX_ONE;
            end
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_last) begin
            r_timer <= '0;
            r_state <= S_STOP;
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_last) begin
            r_timer <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + c_TMR_ONE;
          end
        end
        default: begin
          r_timer <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are pure decodes of the registered state and datapath.
  always_comb begin
    w_ready = 1'b0;
    w_dout  = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        w_busy  = 1'b0;
      end
      S_START:  w_dout = 1'b1;
      S_DATA:   w_dout = r_shift[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: w_dout = r_parity;
`endif
      S_STOP:   w_done = w_bit_last;
      default:  w_busy = 1'b0;
    endcase
  end

  assign tx_if.tx_ready   = w_ready;
  assign tx_if.dout       = w_dout;
  assign tx_if.dout_valid = w_busy;
  assign tx_if.busy       = w_busy;
  assign tx_if.done       = w_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx_fsm
// Brief    : Scoreboard bench driving two instances (BIT_CYCLES 1 and 3).
// Revision : 1.1
// ============================================================================
`timescale 1ns/1ps
module tb_serial_frame_tx_fsm;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic d;
        logic dn;
    } exp_t;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             tx_valid = 1'b0;
    logic [WIDTH-1:0] tx_data  = '0;
    bit               mon_en   = 1'b0;
    int               n_checks = 0;
    int               n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int BC = (g == 0) ? 1 : 3;

        serial_frame_tx_fsm_if #(.WIDTH(WIDTH)) u_if ();

        exp_t       q[$];
        bit         m_idle = 1'b0;
        logic [4:0] act;
        logic [4:0] expv;
        exp_t       e;

        assign u_if.tx_data  = tx_data;
        assign u_if.tx_valid = tx_valid;

        serial_frame_tx_fsm #(
            .WIDTH      (WIDTH),
            .BIT_CYCLES (BC)
        ) u_dut (
            .clk   (clk),
            .rst   (rst),
            .tx_if (u_if)
        );

        always @(clk) begin
            if (clk) begin
                if (rst) begin
                    q.delete();
                end else if (tx_valid && m_idle) begin
                    for (int c = 0; c < BC; c++) q.push_back({1'b1, 1'b0});
                    for (int b = 0; b < WIDTH; b++)
                        for (int c = 0; c < BC; c++) q.push_back({tx_data[b], 1'b0});
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    for (int c = 0; c < BC; c++) q.push_back({^tx_data, 1'b0});
`endif
                    for (int c = 0; c < BC; c++) q.push_back({1'b0, c == BC - 1});
                end
            end else if (mon_en) begin
                act = {u_if.dout_valid, u_if.busy, u_if.tx_ready, u_if.dout, u_if.done};
                if (q.size() != 0) begin
                    e      = q.pop_front();
                    expv   = {3'b110, e.d, e.dn};
                    m_idle = 1'b0;
                end else begin
                    expv   = 5'b00100;
                    m_idle = 1'b1;
                end
                n_checks++;
                if (act !== expv) begin
                    n_errors++;
                    $display("FAIL out_check inst=%0d t=%0t {vld,busy,rdy,dout,done} act=%b exp=%b",
                             g, $time, act, expv);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_bit(input string name, input logic act, input logic expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s t=%0t act=%b exp=%b", name, $time, act, expv);
        end
    endtask

    task automatic check_reset_state();
        check_bit("rst_dout0",  g_inst[0].u_if.dout,       1'b0);
        check_bit("rst_vld0",   g_inst[0].u_if.dout_valid, 1'b0);
        check_bit("rst_busy0",  g_inst[0].u_if.busy,       1'b0);
        check_bit("rst_done0",  g_inst[0].u_if.done,       1'b0);
        check_bit("rst_rdy0",   g_inst[0].u_if.tx_ready,   1'b1);
        check_bit("rst_dout1",  g_inst[1].u_if.dout,       1'b0);
        check_bit("rst_vld1",   g_inst[1].u_if.dout_valid, 1'b0);
        check_bit("rst_busy1",  g_inst[1].u_if.busy,       1'b0);
        check_bit("rst_done1",  g_inst[1].u_if.done,       1'b0);
        check_bit("rst_rdy1",   g_inst[1].u_if.tx_ready,   1'b1);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (!(g_inst[0].u_if.tx_ready && g_inst[1].u_if.tx_ready &&
                 !g_inst[0].u_if.busy && !g_inst[1].u_if.busy) && n < max_cycles) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n >= max_cycles) begin
            n_errors++;
            $display("FAIL wait_idle timeout after %0d cycles t=%0t", max_cycles, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        #2;
        mon_en = 1'b1;
        check_reset_state();
        tick(1);
        rst = 1'b0;
        tick(2);

        send_one(8'hA5, 40);
        send_one(8'h01, 40);
        send_one(8'h07, 40);

        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick(5);
        tx_data  = 8'hFF;
        tick(60);
        tx_valid = 1'b0;
        tick(40);

        send_one(8'hFF, 5);
        rst = 1'b1;
        tick(1);
        check_reset_state();
        rst = 1'b0;
        wait_idle(5);
        send_one(8'h55, 40);
        wait_idle(50);

        tx_data  = 8'h81;
        tx_valid = 1'b1;
        rst      = 1'b1;
        tick(1);
        rst      = 1'b0;
        tx_valid = 1'b0;
        tick(12);

        repeat (400) begin
            tx_valid = 1'($urandom_range(0, 1));
            tx_data  = 8'($urandom);
            tick(1);
        end
        tx_valid = 1'b0;
        tick(40);
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    task automatic send_one(input logic [WIDTH-1:0] w, input int gap);
        tx_data  = w;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(gap);
    endtask

endmodule
`default_nettype wire
